// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns fetch PC, issues 1-cycle imem reads, buffers {pc, word} in a DEPTH-entry prefetch FIFO.
// Request-to-valid latency 2 cycles; stops requesting when FIFO plus in-flight would exceed DEPTH; redirect flushes.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_word_q [DEPTH];

  logic          pop;
  logic          push;
  logic [CW:0]   occupancy;

  always_comb begin
    instr_valid = !reset && (count_q != '0);
    instruction = instr_valid ? fifo_word_q[rd_ptr_q] : 32'h0;
    instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    pop         = instr_valid && instr_ready;

    // Slots already promised: buffered words plus the response due now, minus what leaves this cycle.
    occupancy   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_req    = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
    imem_addr   = reset ? RESET_PC : fetch_pc_q;
    push        = inflight_q && !kill_q && !redirect && !reset;

    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = imem_req;
    kill_d      = redirect;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (imem_req) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0:   mem_f = 32'h0000_8183;
      32'h4:   mem_f = 32'h0041_01A3;
      32'h8:   mem_f = 32'h4062_8233;
      32'hC:   mem_f = 32'h0094_73B3;
      default: mem_f = (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Synchronous instruction memory: data one cycle after the request, garbage otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? mem_f(imem_addr) : $urandom;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched {pc, word}, next fetch address, one outstanding request.
  typedef struct packed { logic [31:0] pc; logic [31:0] word; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch = RESET_PC;
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  bit          e_req = 1'b0;
  bit          e_pop = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      e_req = 1'b0;
      e_pop = 1'b0;
      chk1("m_rst_req", imem_req, 1'b0);
      chk("m_rst_addr", imem_addr, RESET_PC);
      chk1("m_rst_valid", instr_valid, 1'b0);
      chk("m_rst_instr", instruction, 32'h0);
      chk("m_rst_pc", instr_pc, 32'h0);
    end else begin
      e_pop = (mq.size() > 0) && instr_ready;
      e_req = !redirect && ((mq.size() + int'(m_infl) - int'(e_pop)) < DEPTH);
      chk1("m_valid", instr_valid, mq.size() > 0);
      chk("m_instr", instruction, (mq.size() > 0) ? mq[0].word : 32'h0);
      chk("m_pc", instr_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
      chk1("m_req", imem_req, e_req);
      if (e_req) chk("m_addr", imem_addr, m_fetch);
      if (!redirect && dut.inflight_q && !dut.kill_q && int'(dut.count_q) == DEPTH) begin
        checks++;
        errs++;
        $display("FAIL push_on_full: count=%0d expected below %0d at %0t", dut.count_q, DEPTH, $time);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_fetch = RESET_PC;
      m_infl  = 1'b0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (redirect) begin
        mq.delete();
        m_fetch = redirect_pc & 32'hFFFF_FFFC;
        m_infl  = 1'b0;
      end else begin
        if (m_infl) mq.push_back('{pc: m_infl_pc, word: mem_f(m_infl_pc)});
        if (e_req) begin
          m_infl_pc = m_fetch;
          m_fetch   = m_fetch + 32'd4;
        end
        m_infl = e_req;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [31:0] tp_words [4] = '{32'h0000_8183, 32'h0041_01A3, 32'h4062_8233, 32'h0094_73B3};

  initial begin
    int nreq;

    // Reset, then steady streaming of the four program words.
    smp();
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk1("rst_valid", instr_valid, 1'b0);
    nxt(); nxt();
    reset = 1'b0;
    smp(); chk1("c0_req", imem_req, 1'b1); chk("c0_addr", imem_addr, 32'h0); nxt();
    smp(); chk1("c1_valid", instr_valid, 1'b0); nxt();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk1("stream_valid", instr_valid, 1'b1);
      chk("stream_instr", instruction, tp_words[i]);
      chk("stream_pc", instr_pc, 32'(4 * i));
      nxt();
    end

    // Hold ready low: exactly DEPTH requests, then refill when released.
    reset = 1'b1; nxt();
    reset = 1'b0; instr_ready = 1'b0; nreq = 0;
    for (int i = 0; i < 10; i++) begin
      smp(); nreq += int'(imem_req); nxt();
    end
    chk("hold_reqs", 32'(nreq), 32'd2);
    smp(); chk1("hold_idle", imem_req, 1'b0); chk("hold_head", instr_pc, 32'h0); nxt();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk1("drain_valid", instr_valid, 1'b1); chk("drain_pc", instr_pc, 32'(4 * i)); nxt();
    end

    // Redirect mid-stream to an unaligned target.
    nxt(); nxt();
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    smp(); chk1("redir_noreq", imem_req, 1'b0); nxt();
    redirect = 1'b0;
    smp(); chk1("redir_r1_req", imem_req, 1'b1); chk("redir_r1_addr", imem_addr, 32'h40);
    chk1("redir_r1_valid", instr_valid, 1'b0); nxt();
    smp(); chk1("redir_r2_valid", instr_valid, 1'b0); nxt();
    smp(); chk1("redir_r3_valid", instr_valid, 1'b1); chk("redir_r3_pc", instr_pc, 32'h40);
    chk("redir_r3_instr", instruction, mem_f(32'h40)); nxt();

    // Back-to-back redirects: the later one wins.
    redirect = 1'b1; redirect_pc = 32'h100; nxt();
    redirect_pc = 32'h200; nxt();
    redirect = 1'b0;
    smp(); chk("b2b_addr", imem_addr, 32'h200); chk1("b2b_req", imem_req, 1'b1); nxt();
    smp(); chk1("b2b_gap", instr_valid, 1'b0); nxt();
    smp(); chk("b2b_pc0", instr_pc, 32'h200); nxt();
    smp(); chk("b2b_pc1", instr_pc, 32'h204); nxt();

    // Reset mid-stream with a response pending.
    nxt();
    reset = 1'b1;
    smp(); chk1("mrst_valid", instr_valid, 1'b0); chk("mrst_instr", instruction, 32'h0);
    chk("mrst_pc", instr_pc, 32'h0); chk1("mrst_req", imem_req, 1'b0); nxt();
    reset = 1'b0;
    smp(); chk("mrst_c0_addr", imem_addr, RESET_PC); nxt();
    smp(); chk1("mrst_c1_valid", instr_valid, 1'b0); nxt();
    smp(); chk("mrst_c2_pc", instr_pc, 32'h0); chk("mrst_c2_instr", instruction, 32'h0000_8183); nxt();

    // Fetch PC wraps past the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; nxt();
    redirect = 1'b0;
    smp(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); nxt();
    smp(); chk1("wrap_req1", imem_req, 1'b1); chk("wrap_addr1", imem_addr, 32'h0); nxt();
    smp(); chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC); nxt();
    smp(); chk("wrap_pc1", instr_pc, 32'h0); nxt();

    // Random traffic: ready stalls, redirects (some near the wrap point), occasional resets.
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      reset       = ($urandom_range(0, 99) == 0);
      nxt();
    end
    reset = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    nxt(); nxt();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
